psram_qspi_burst_writer: RTL and testbench
==========================================

Name: psram_qspi_burst_writer

Overview:
- Consumer end of the write-data FIFO in the PSRAM controller.
- On a start request it issues a QPI write (command, 24-bit address, data burst) to the PSRAM. Data bytes are popped from the FIFO's registered read port and serialized as nibbles, MSB nibble first.
- FIFO underruns stall SCLK with CE held low. A bounded stall aborts the burst and reports an error.

Parameters:
- addr_width, 24, PSRAM byte address width; must be a multiple of 4.
- len_bits, 8, width of burst length field.
- cmd_write, 8'h38, QPI write command opcode.
- max_stall, 15, max consecutive clk cycles waiting on an empty FIFO before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  burst request; sampled only when busy=0.
- addr  in  addr_width  burst start address; latched with start.
- len  in  len_bits  burst length minus one (0 = 1 byte).
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_re.
- fifo_empty  in  1  FIFO empty flag.
- fifo_re  out  1  FIFO pop strobe, one cycle per byte.
- psram_ce_n  out  1  chip enable, active low.
- psram_sclk  out  1  serial clock = clk/2 while running.
- psram_dq_o  out  4  quad data out.
- psram_dq_oe  out  1  DQ output enable.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err_underrun  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values:
  - ce_n=1; sclk=0; dq_o=0; dq_oe=0.
  - fifo_re=0; busy=0; done=0; err_underrun=0.
  - State IDLE; all counters 0.
  - Reset mid-burst drops CE immediately. No done or err pulse.
- Nibble timing: each nibble spans 2 clks.
  - Phase 0: sclk=0, dq_o updated.
  - Phase 1: sclk=1.
- States and transitions:
  - IDLE: on start, latch addr and len, set busy=1, go to CMD. Start while busy is ignored.
  - CMD: 2 nibbles of cmd_write. ce_n=0 and dq_oe=1 from the first CMD cycle.
  - ADDR: addr_width/4 nibbles, MSB first. In the second-to-last ADDR cycle, fifo_re=1 if fifo_empty=0. The captured byte loads the data shift register.
  - DATA: 2 nibbles per byte.
    - In the first phase-1 cycle of a byte's high nibble, pop the next byte (fifo_re=1) if bytes remain and fifo_empty=0.
    - Byte counter counts down from len; the last byte is sent at count 0.
  - STALL: entered when the next byte is needed but no pop was possible (FIFO empty).
    - Hold sclk=0, ce_n=0, dq_oe=1, dq_o unchanged.
    - Stall counter increments every cycle.
    - When fifo_empty=0: pop, then resume DATA phase 0 two cycles later.
    - When the counter reaches max_stall: go to ABORT.
  - FINISH: after the last nibble's phase 1, one cycle with sclk=0 and ce_n=0. Then ce_n=1 and dq_oe=0, done=1 for one cycle, go to IDLE (busy=0).
  - ABORT: ce_n=1, dq_oe=0, err_underrun=1 for one cycle, go to IDLE.
- Nominal burst of N=len+1 bytes with no stalls: ce_n low for 4 + 2*addr_width/4 + 4N + 1 clks. For the defaults this is 17+4N.
- fifo_re is never asserted when fifo_empty=1. It is never asserted more than len+1 times per burst.
- Byte counter width is len_bits; len=2^len_bits-1 must work without wrap error.

Decomposition:
- Shared package psram_pkg:
  - state encoding (IDLE, CMD, ADDR, DATA, STALL, FINISH, ABORT);
  - QPI opcode constants (cmd_write, cmd_read);
  - nibble-count constants.
- One natural sub-module: psram_nibble_shifter, the load/shift register producing dq_o with the phase toggle generating sclk. Reused by the future read path.

Test Plan:
- Single byte: addr=0x001234, len=0, FIFO pre-loaded 0xA5.
  - dq_o nibbles: 3,8,0,0,1,2,3,4,A,5.
  - ce_n low 21 clks; one fifo_re; done pulse; busy falls the cycle after done.
- Burst: len=3, FIFO holds 0x11,0x22,0x33,0x44 → data nibbles 1,1,2,2,3,3,4,4, exactly 4 fifo_re pulses, ce_n low 33 clks.
- Underrun recovery: len=1, FIFO holds 1 byte, push second byte 6 clks after the first byte finishes → sclk held low during the stall, then data resumes, done=1, err_underrun=0.
- Underrun abort: len=1, FIFO holds 1 byte and is never refilled → after 15 stall clks, ce_n=1, err_underrun pulses once, no done, busy=0.
- Start while busy, and reset mid-DATA:
  - Start while busy is ignored; busy stays high.
  - rst=0 mid-DATA forces ce_n=1, sclk=0, fifo_re=0 in the same cycle.
  - A later start runs a clean burst.
- Max length: len=255 with a continuously filled FIFO → exactly 256 pops, 512 data nibbles, single done.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared PSRAM controller definitions: FSM encoding, QPI opcodes and nibble counts.
package psram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StStall,
        StFinish,
        StAbort
    } state_e;

    localparam logic [7:0] qpi_cmd_write = 8'h38;
    localparam logic [7:0] qpi_cmd_read  = 8'hEB;

    localparam int unsigned cmd_nibbles      = 2;
    localparam int unsigned nibbles_per_byte = 2;

endpackage

// File: rtl/psram_nibble_shifter.sv
// Load/shift register presenting its top nibble on DQ; a phase toggle provides SCLK.
module psram_nibble_shifter #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             step,
    input  logic             shift,
    output logic [3:0]       dq,
    output logic             sclk
);

    logic             phase_q, phase_d;
    logic [width-1:0] sr_q, sr_d;

    always_comb begin
        phase_d = step ? ~phase_q : phase_q;
        sr_d    = sr_q;
        if (load) begin
            sr_d = load_val;
        end else if (shift) begin
            sr_d = {sr_q[width-5:0], 4'h0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= 1'b0;
            sr_q    <= '0;
        end else begin
            phase_q <= phase_d;
            sr_q    <= sr_d;
        end
    end

    assign dq   = sr_q[width-1 -: 4];
    assign sclk = phase_q;

endmodule

// File: rtl/psram_qspi_burst_writer.sv
// QPI write burst engine: pops bytes from the write FIFO and streams cmd, address and data
// nibbles to the PSRAM, stalling SCLK on underrun and aborting after a bounded wait.
module psram_qspi_burst_writer
    import psram_pkg::*;
#(
    parameter int unsigned addr_width = 24,
    parameter int unsigned len_bits   = 8,
    parameter logic [7:0]  cmd_write  = qpi_cmd_write,
    parameter int unsigned max_stall  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] addr,
    input  logic [len_bits-1:0]   len,
    input  logic [7:0]            fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    output logic                  psram_ce_n,
    output logic                  psram_sclk,
    output logic [3:0]            psram_dq_o,
    output logic                  psram_dq_oe,
    output logic                  busy,
    output logic                  done,
    output logic                  err_underrun
);

    localparam int unsigned addr_nibbles = addr_width / 4;
    localparam int unsigned sr_width     = 8 + addr_width;
    localparam int unsigned nib_w        = $clog2(addr_nibbles + 1);
    localparam int unsigned stall_w      = $clog2(max_stall + 1);

    state_e               state_q, state_d;
    logic [nib_w-1:0]     nib_q, nib_d;
    logic [len_bits-1:0]  cnt_q, cnt_d;
    logic [stall_w-1:0]   stall_q, stall_d;
    logic                 first_q, first_d;
    logic                 have_q, have_d;
    logic                 popped_q, popped_d;
    logic                 fin_q, fin_d;
    logic                 re_q;
    logic [7:0]           nxt_q;

    logic                 load, shift, step, take_byte;
    logic [sr_width-1:0]  load_val;
    logic                 avail, last_addr;
    logic [7:0]           byte_src;

    // A popped byte is either on the FIFO read port this cycle or parked in nxt_q.
    assign avail     = re_q | have_q;
    assign byte_src  = re_q ? fifo_data : nxt_q;
    assign last_addr = (nib_q == nib_w'(addr_nibbles - 1));
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        nib_d        = nib_q;
        cnt_d        = cnt_q;
        stall_d      = stall_q;
        first_d      = first_q;
        have_d       = have_q | re_q;
        popped_d     = popped_q;
        fin_d        = fin_q;
        load         = 1'b0;
        load_val     = {cmd_write, addr};
        shift        = 1'b0;
        step         = 1'b0;
        take_byte    = 1'b0;
        fifo_re      = 1'b0;
        psram_ce_n   = 1'b1;
        psram_dq_oe  = 1'b0;
        done         = 1'b0;
        err_underrun = 1'b0;

        unique case (state_q)
            StIdle: begin
                have_d = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = len;
                    first_d = 1'b1;
                    nib_d   = '0;
                    fin_d   = 1'b0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                psram_ce_n  = 1'b0;
                psram_dq_oe = 1'b1;
                step        = 1'b1;
                if (psram_sclk) begin
                    shift = 1'b1;
                    if (nib_q == nib_w'(cmd_nibbles - 1)) begin
                        nib_d   = '0;
                        state_d = StAddr;
                    end else begin
                        nib_d = nib_q + 1'b1;
                    end
                end
            end
            StAddr: begin
                psram_ce_n  = 1'b0;
                psram_dq_oe = 1'b1;
                step        = 1'b1;
                // First data byte is fetched early so it is on the read port at the hand-off.
                if (!psram_sclk && last_addr && !fifo_empty) begin
                    fifo_re = 1'b1;
                end
                if (psram_sclk) begin
                    if (!last_addr) begin
                        nib_d = nib_q + 1'b1;
                        shift = 1'b1;
                    end else if (avail) begin
                        take_byte = 1'b1;
                        state_d   = StData;
                    end else begin
                        stall_d  = '0;
                        popped_d = 1'b0;
                        state_d  = StStall;
                    end
                end
            end
            StData: begin
                psram_ce_n  = 1'b0;
                psram_dq_oe = 1'b1;
                step        = 1'b1;
                if (psram_sclk) begin
                    if (nib_q == '0) begin
                        fifo_re = (cnt_q != '0) && !fifo_empty;
                        nib_d   = nib_w'(nibbles_per_byte - 1);
                        shift   = 1'b1;
                    end else if (cnt_q == '0) begin
                        fin_d   = 1'b0;
                        state_d = StFinish;
                    end else if (avail) begin
                        take_byte = 1'b1;
                    end else begin
                        stall_d  = '0;
                        popped_d = 1'b0;
                        state_d  = StStall;
                    end
                end
            end
            StStall: begin
                psram_ce_n  = 1'b0;
                psram_dq_oe = 1'b1;
                stall_d     = stall_q + 1'b1;
                if (popped_q) begin
                    take_byte = 1'b1;
                    state_d   = StData;
                end else if (!fifo_empty) begin
                    fifo_re  = 1'b1;
                    popped_d = 1'b1;
                end else if (stall_q == stall_w'(max_stall - 1)) begin
                    state_d = StAbort;
                end
            end
            StFinish: begin
                if (!fin_q) begin
                    psram_ce_n  = 1'b0;
                    psram_dq_oe = 1'b1;
                    fin_d       = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StAbort: begin
                err_underrun = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The count stays at len for byte 0 so the final byte goes out at count 0.
        if (take_byte) begin
            load     = 1'b1;
            load_val = {byte_src, {addr_width{1'b0}}};
            have_d   = 1'b0;
            nib_d    = '0;
            first_d  = 1'b0;
            if (!first_q) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            nib_q    <= '0;
            cnt_q    <= '0;
            stall_q  <= '0;
            first_q  <= 1'b0;
            have_q   <= 1'b0;
            popped_q <= 1'b0;
            fin_q    <= 1'b0;
            re_q     <= 1'b0;
            nxt_q    <= '0;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            first_q  <= first_d;
            have_q   <= have_d;
            popped_q <= popped_d;
            fin_q    <= fin_d;
            re_q     <= fifo_re;
            if (re_q) begin
                nxt_q <= fifo_data;
            end
        end
    end

    psram_nibble_shifter #(
        .width(sr_width)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .step    (step),
        .shift   (shift),
        .dq      (psram_dq_o),
        .sclk    (psram_sclk)
    );

endmodule

// File: tb/tb_psram_qspi_burst_writer.sv
// Directed bench for the QPI burst writer with a behavioural FIFO (registered read port).
module tb_psram_qspi_burst_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_re;
    logic        psram_ce_n;
    logic        psram_sclk;
    logic [3:0]  psram_dq_o;
    logic        psram_dq_oe;
    logic        busy;
    logic        done;
    logic        err_underrun;

    int total = 0;
    int bad   = 0;

    psram_qspi_burst_writer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .addr        (addr),
        .len         (len),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_re     (fifo_re),
        .psram_ce_n  (psram_ce_n),
        .psram_sclk  (psram_sclk),
        .psram_dq_o  (psram_dq_o),
        .psram_dq_oe (psram_dq_oe),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: bench writes mem/wr_ptr, read side advances on fifo_re.
    logic [7:0]  mem [0:1023];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        flush;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_re && !fifo_empty) begin
            fifo_data <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Cumulative observations sampled mid-cycle.
    int         ce_low = 0;
    int         ce_low_sclk_low = 0;
    int         re_cnt = 0;
    int         re_bad = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         nib_total = 0;
    logic [3:0] nib_log [0:4095];

    always @(negedge clk) begin
        if (!psram_ce_n) begin
            ce_low <= ce_low + 1;
            if (!psram_sclk) ce_low_sclk_low <= ce_low_sclk_low + 1;
        end
        if (fifo_re) re_cnt <= re_cnt + 1;
        if (fifo_re && fifo_empty) re_bad <= re_bad + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (err_underrun) err_cnt <= err_cnt + 1;
        if (psram_sclk) begin
            nib_log[nib_total[11:0]] <= psram_dq_o;
            nib_total <= nib_total + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[9:0]] = b;
        wr_ptr++;
    endtask

    task automatic start_burst(input logic [23:0] a, input logic [7:0] l);
        addr  = a;
        len   = l;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || err_underrun) && n < budget) begin
            cyc();
            n++;
        end
        chk("burst_end_seen", {31'b0, done | err_underrun}, 1);
        chk("ce_n_at_end", {31'b0, psram_ce_n}, 1);
        chk("busy_at_end", {31'b0, busy}, 1);
        cyc();
        chk("busy_after_end", {31'b0, busy}, 0);
    endtask

    task automatic chk_nibbles(input string tag, input int base, input logic [23:0] a,
                               input int dp, input int nbytes, input int got_n);
        logic [31:0] hdr;
        logic [7:0]  by;
        logic [3:0]  e;
        int          idx;
        int          mism;
        hdr  = {8'h38, a};
        mism = 0;
        chk({tag, "_nib_count"}, got_n, 8 + 2 * nbytes);
        for (int k = 0; k < 8 + 2 * nbytes; k++) begin
            if (k < 8) begin
                e = hdr[31 - 4 * k -: 4];
            end else begin
                idx = dp + (k - 8) / 2;
                by  = mem[idx[9:0]];
                e   = ((k - 8) % 2 == 0) ? by[7:4] : by[3:0];
            end
            idx = base + k;
            if (nib_log[idx[11:0]] !== e) mism++;
        end
        chk({tag, "_nib_mismatch"}, mism, 0);
    endtask

    task automatic do_burst(input string tag, input logic [23:0] a, input logic [7:0] l,
                            input int dp, input int budget, input int exp_ce,
                            input int exp_pops);
        int b_ce, b_re, b_done, b_err, b_nib;
        b_ce   = ce_low;
        b_re   = re_cnt;
        b_done = done_cnt;
        b_err  = err_cnt;
        b_nib  = nib_total;
        start_burst(a, l);
        wait_end(budget);
        chk({tag, "_ce_low"}, ce_low - b_ce, exp_ce);
        chk({tag, "_pops"}, re_cnt - b_re, exp_pops);
        chk({tag, "_done"}, done_cnt - b_done, 1);
        chk({tag, "_err"}, err_cnt - b_err, 0);
        chk_nibbles(tag, b_nib, a, dp, int'(l) + 1, nib_total - b_nib);
    endtask

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  len;
        logic [31:0] data;
        logic [7:0]  ce_low;
        logic [7:0]  pops;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int          dp;
        int          b_ce, b_cs, b_re, b_done, b_err, b_nib;
        logic [31:0] d;

        vecs[0] = '{addr: 24'h001234, len: 8'd0, data: 32'hA5000000, ce_low: 8'd21, pops: 8'd1};
        vecs[1] = '{addr: 24'h400100, len: 8'd3, data: 32'h11223344, ce_low: 8'd33, pops: 8'd4};
        vecs[2] = '{addr: 24'hFEDCBA, len: 8'd1, data: 32'h0FF00000, ce_low: 8'd25, pops: 8'd2};
        vecs[3] = '{addr: 24'h5A5A5A, len: 8'd2, data: 32'hC3963C00, ce_low: 8'd29, pops: 8'd3};

        rst   = 1'b0;
        start = 1'b0;
        addr  = '0;
        len   = '0;
        flush = 1'b0;
        repeat (3) cyc();
        chk("rst_ce_n", {31'b0, psram_ce_n}, 1);
        chk("rst_sclk", {31'b0, psram_sclk}, 0);
        chk("rst_dq_o", {28'b0, psram_dq_o}, 0);
        chk("rst_dq_oe", {31'b0, psram_dq_oe}, 0);
        chk("rst_fifo_re", {31'b0, fifo_re}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done_err", {30'b0, done, err_underrun}, 0);
        rst = 1'b1;
        cyc();

        for (int v = 0; v < 4; v++) begin
            dp = int'(wr_ptr);
            d  = vecs[v].data;
            for (int i = 0; i <= int'(vecs[v].len); i++) push(d[31 - 8 * i -: 8]);
            do_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, dp, 200,
                     int'(vecs[v].ce_low), int'(vecs[v].pops));
        end

        // Underrun recovery: second byte arrives 6 clks after byte 0 finishes.
        dp = int'(wr_ptr);
        push(8'h5C);
        b_ce = ce_low; b_cs = ce_low_sclk_low; b_re = re_cnt;
        b_done = done_cnt; b_err = err_cnt; b_nib = nib_total;
        start_burst(24'h0C0FFE, 8'd1);
        repeat (25) cyc();
        push(8'h7E);
        wait_end(200);
        chk("recov_ce_low", ce_low - b_ce, 32);
        chk("recov_sclk_low", ce_low_sclk_low - b_cs, 20);
        chk("recov_pops", re_cnt - b_re, 2);
        chk("recov_done", done_cnt - b_done, 1);
        chk("recov_err", err_cnt - b_err, 0);
        chk_nibbles("recov", b_nib, 24'h0C0FFE, dp, 2, nib_total - b_nib);

        // Underrun abort: second byte never arrives.
        dp = int'(wr_ptr);
        push(8'h99);
        b_ce = ce_low; b_re = re_cnt; b_done = done_cnt; b_err = err_cnt; b_nib = nib_total;
        start_burst(24'h123456, 8'd1);
        wait_end(200);
        chk("abort_ce_low", ce_low - b_ce, 35);
        chk("abort_pops", re_cnt - b_re, 1);
        chk("abort_done", done_cnt - b_done, 0);
        chk("abort_err", err_cnt - b_err, 1);
        chk_nibbles("abort", b_nib, 24'h123456, dp, 1, nib_total - b_nib);

        // Start while busy is ignored, then reset in the middle of the data phase.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        b_done = done_cnt; b_err = err_cnt;
        start_burst(24'h222222, 8'd3);
        repeat (5) cyc();
        start = 1'b1;
        addr  = 24'hFFFFFF;
        len   = 8'd0;
        cyc();
        start = 1'b0;
        chk("ignored_start_busy", {31'b0, busy}, 1);
        repeat (11) cyc();
        chk("mid_pop_fifo_re", {31'b0, fifo_re}, 1);
        chk("mid_pop_sclk", {31'b0, psram_sclk}, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ce_n", {31'b0, psram_ce_n}, 1);
        chk("mid_rst_sclk", {31'b0, psram_sclk}, 0);
        chk("mid_rst_fifo_re", {31'b0, fifo_re}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        flush = 1'b1;
        cyc();
        cyc();
        flush = 1'b0;
        rst   = 1'b1;
        cyc();
        chk("mid_rst_no_done", done_cnt - b_done, 0);
        chk("mid_rst_no_err", err_cnt - b_err, 0);

        dp = int'(wr_ptr);
        push(8'h3C);
        do_burst("clean", 24'hABCDEF, 8'd0, dp, 200, 21, 1);

        // Maximum length burst with a FIFO that never runs dry.
        dp = int'(wr_ptr);
        for (int i = 0; i < 256; i++) push(8'(i) ^ 8'h5A);
        do_burst("maxlen", 24'h000100, 8'd255, dp, 2000, 1041, 256);

        chk("re_while_empty", re_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
